// File: rtl/timer_ctrl.sv
// Sequencing controller for the 32-bit timer counter: prescaled count ticks,
// terminal-value reload/stop, compare detection and W1C status/interrupt.
module timer_ctrl #(
    parameter int unsigned PSC_W = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             start,
    input  logic             stop,
    input  logic             soft_load,
    input  logic             mode_down,
    input  logic             auto_reload,
    input  logic [PSC_W-1:0] psc,
    input  logic [31:0]      cmp_val,
    input  logic             ovf_ie,
    input  logic             udf_ie,
    input  logic             cmp_ie,
    input  logic [2:0]       flag_clr,
    input  logic [31:0]      cnt,
    input  logic [31:0]      last_cnt,
    output logic             load,
    output logic             en,
    output logic             updown,
    output logic             count_enable,
    output logic             ovf_flag,
    output logic             udf_flag,
    output logic             cmp_flag,
    output logic             irq,
    output logic             busy
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned FLAG_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PSC_W-1:0]  pc_q, pc_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic              dir_q, dir_d;
    logic              ar_q, ar_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic              is_run;
    logic              tick;
    logic              at_term;
    logic              term;
    logic              cmp_evt;
    logic [FLAG_W-1:0] flag_set;

    // Terminal value is all-ones counting up, zero counting down.
    always_comb begin
        is_run   = (state_q == ST_RUN);
        tick     = is_run && (pc_q == psc_q);
        at_term  = dir_q ? (cnt == CNT_W'(0)) : (cnt == {CNT_W{1'b1}});
        term     = tick && at_term;
        cmp_evt  = is_run && (cnt != last_cnt) && (cnt == cmp_val);
        flag_set = {cmp_evt, term && dir_q, term && !dir_q};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        psc_d   = psc_q;
        dir_d   = dir_q;
        ar_d    = ar_q;
        flags_d = (flags_q & ~flag_clr) | flag_set;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                dir_d   = mode_down;
                ar_d    = auto_reload;
                psc_d   = psc;
                pc_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_d = tick ? '0 : pc_q + PSC_W'(1);
                if (soft_load)         state_d = ST_LOAD;
                else if (term && !ar_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) state_d = ST_IDLE;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            psc_q   <= '0;
            dir_q   <= 1'b0;
            ar_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            psc_q   <= psc_d;
            dir_q   <= dir_d;
            ar_q    <= ar_d;
            flags_q <= flags_d;
        end
    end

    // Strobes decode directly from registered state so the counter sees no extra latency.
    assign load         = (state_q == ST_LOAD) || (term && ar_q);
    assign en           = is_run;
    assign updown       = dir_q;
    assign count_enable = tick && !term;
    assign busy         = (state_q != ST_IDLE);

    assign ovf_flag = flags_q[0];
    assign udf_flag = flags_q[1];
    assign cmp_flag = flags_q[2];
    assign irq      = |(flags_q & {cmp_ie, udf_ie, ovf_ie});

endmodule
